// File: rtl/absdiff_serial.sv
// Iterative |in0 - in1| unit: a p_dbits-wide digit subtractor is reused LSD-first over
// K = p_nbits/p_dbits cycles, with a second K-cycle pass to negate a borrowing result.
module absdiff_serial #(
    parameter int p_nbits = 8,
    parameter int p_dbits = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_val,
    output logic               in_rdy,
    input  logic [p_nbits-1:0] in0,
    input  logic [p_nbits-1:0] in1,
    output logic               out_val,
    input  logic               out_rdy,
    output logic [p_nbits-1:0] out,
    output logic               out_neg
);

    localparam int K  = p_nbits / p_dbits;
    localparam int CW = $clog2(K + 1);
    localparam logic [CW-1:0] LAST_DIGIT = CW'(K - 1);
    localparam logic [CW-1:0] DECIDE     = CW'(K);

    if ((p_nbits % p_dbits) != 0 || p_nbits < 2) begin : g_param_check
        $error("absdiff_serial: p_dbits (%0d) must divide p_nbits (%0d), p_nbits >= 2",
               p_dbits, p_nbits);
    end

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        NEG,
        DONE
    } state_e;

    state_e             state_q;
    logic [p_nbits-1:0] a_q;
    logic [p_nbits-1:0] b_q;
    logic [p_nbits-1:0] r_q;
    logic               borrow_q;
    logic [CW-1:0]      cnt_q;
    logic               neg_q;
    logic               in_rdy_q;
    logic               out_val_q;

    logic [p_dbits:0]   diff_d;
    logic [p_nbits-1:0] a_d;
    logic [p_nbits-1:0] b_d;
    logic [p_nbits-1:0] r_d;
    logic [p_nbits-1:0] digit_ext;

    // One digit step: the extra MSB of diff_d is the outgoing borrow.
    always_comb begin
        diff_d    = {1'b0, a_q[p_dbits-1:0]} - {1'b0, b_q[p_dbits-1:0]}
                    - (p_dbits + 1)'(borrow_q);
        a_d       = a_q >> p_dbits;
        b_d       = b_q >> p_dbits;
        digit_ext = p_nbits'(diff_d[p_dbits-1:0]);
        r_d       = (r_q >> p_dbits) | (digit_ext << (p_nbits - p_dbits));
    end

    // NOTE: state is written only with non-blocking assignments so every register samples
    // pre-edge values; the asynchronous reset sits in the sensitivity list.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            r_q       <= '0;
            borrow_q  <= 1'b0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            in_rdy_q  <= 1'b1;
            out_val_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_val) begin
                        a_q      <= in0;
                        b_q      <= in1;
                        r_q      <= '0;
                        borrow_q <= 1'b0;
                        cnt_q    <= '0;
                        in_rdy_q <= 1'b0;
                        state_q  <= SUB;
                    end
                end
                SUB: begin
                    if (cnt_q != DECIDE) begin
                        a_q      <= a_d;
                        b_q      <= b_d;
                        r_q      <= r_d;
                        borrow_q <= diff_d[p_dbits];
                        cnt_q    <= cnt_q + 1'b1;
                    end else if (borrow_q) begin
                        // Negative difference: rerun the datapath as 0 - R.
                        neg_q    <= 1'b1;
                        a_q      <= '0;
                        b_q      <= r_q;
                        borrow_q <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= NEG;
                    end else begin
                        neg_q     <= 1'b0;
                        out_val_q <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                NEG: begin
                    a_q      <= a_d;
                    b_q      <= b_d;
                    r_q      <= r_d;
                    borrow_q <= diff_d[p_dbits];
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == LAST_DIGIT) begin
                        out_val_q <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    if (out_rdy) begin
                        out_val_q <= 1'b0;
                        in_rdy_q  <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_rdy  = in_rdy_q;
    assign out_val = out_val_q;
    assign out     = r_q;
    assign out_neg = neg_q;

endmodule
